// File: rtl/difftest_dma_pkg.sv
// rtl/difftest_dma_pkg.sv - packet geometry, packer state type and packet builder for the difftest DMA packer
package difftest_dma_pkg;

  localparam int FRAME_W  = 4064;
  localparam int PKT_W    = 4096;
  localparam int SEQ_W    = 8;
  localparam int SEQ_LSB  = 4064;
  localparam int STEP_BIT = 4072;
  localparam int ZEON_BIT = 4073;

  typedef enum logic {
    IDLE,
    SEND
  } packer_state_e;

  // Lays a gateway frame and its side-band fields out as one host packet; spare top bits are zero.
  function automatic logic [PKT_W-1:0] build_packet(
    input logic [FRAME_W-1:0] data,
    input logic               step,
    input logic               zeon,
    input logic [SEQ_W-1:0]   seq
  );
    logic [PKT_W-1:0] pkt;
    pkt                   = '0;
    pkt[FRAME_W-1:0]      = data;
    pkt[SEQ_LSB +: SEQ_W] = seq;
    pkt[STEP_BIT]         = step;
    pkt[ZEON_BIT]         = zeon;
    return pkt;
  endfunction

endpackage

// File: rtl/difftest_frame_fifo.sv
// rtl/difftest_frame_fifo.sv - whole-packet FIFO; head entry is read straight from register storage
module difftest_frame_fifo
  import difftest_dma_pkg::*;
#(
  parameter int WIDTH = PKT_W,
  parameter int DEPTH = 2
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      cnt;
  logic             do_push;
  logic             do_pop;

  // A pop frees the head slot in the same cycle, so a full FIFO may still take a push alongside it.
  assign do_pop  = pop && (cnt != '0);
  assign do_push = push && ((cnt != (AW+1)'(DEPTH)) || do_pop);

  assign full    = (cnt == (AW+1)'(DEPTH));
  assign empty   = (cnt == '0);
  assign count   = cnt;
  assign rd_data = mem[rd_ptr];

  // Pointer and occupancy bookkeeping; power-of-two depth lets the pointers wrap naturally.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  // Packet storage; contents are meaningless until written, so it carries no reset.
  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/difftest_dma_packer.sv
// rtl/difftest_dma_packer.sv - buffers difftest frames and streams them as AXIS beats; DIFFTEST_DMA_STATS_EN adds frame/drop counters
module difftest_dma_packer
  import difftest_dma_pkg::*;
#(
  parameter int DATA_W     = 512,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic [FRAME_W-1:0]  in_data,
  input  logic                in_enable,
  input  logic                in_step,
  input  logic                in_zeon,
  output logic [DATA_W-1:0]   m_axis_tdata,
  output logic [DATA_W/8-1:0] m_axis_tkeep,
  output logic                m_axis_tvalid,
  input  logic                m_axis_tready,
  output logic                m_axis_tlast,
  output logic                overflow
`ifdef DIFFTEST_DMA_STATS_EN
  ,
  output logic [31:0]         frame_cnt,
  output logic [31:0]         drop_cnt
`endif
);

  localparam int N_BEATS = PKT_W / DATA_W;
  localparam int BEAT_W  = $clog2(N_BEATS);
  localparam int CNT_W   = $clog2(FIFO_DEPTH) + 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(N_BEATS - 1);

  packer_state_e      state;
  logic [BEAT_W-1:0]  beat_idx;
  logic [SEQ_W-1:0]   seq;
  logic [PKT_W-1:0]   wr_pkt;
  logic [PKT_W-1:0]   head_pkt;
  logic [DATA_W-1:0]  beats [N_BEATS];
  logic               fifo_full;
  logic               fifo_empty;
  logic [CNT_W-1:0]   fifo_count;
  logic               handshake;
  logic               pop;
  logic               push;
  logic               drop;

  // The gateway cannot be stalled: a frame is taken only if a slot is free now or freed by this cycle's final beat.
  assign handshake = m_axis_tvalid && m_axis_tready;
  assign pop       = handshake && m_axis_tlast;
  assign push      = in_enable && (!fifo_full || pop);
  assign drop      = in_enable && !push;
  assign wr_pkt    = build_packet(in_data, in_step, in_zeon, seq);

  difftest_frame_fifo #(
    .WIDTH (PKT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock   (clock),
    .reset_n (reset_n),
    .push    (push),
    .wr_data (wr_pkt),
    .pop     (pop),
    .rd_data (head_pkt),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  // Slice the head packet into beats; beat 0 holds the least significant bits.
  always_comb begin
    for (int k = 0; k < N_BEATS; k++) begin
      beats[k] = head_pkt[k*DATA_W +: DATA_W];
    end
  end

  // Data comes from registered state only and is forced to zero whenever no beat is offered.
  assign m_axis_tdata = m_axis_tvalid ? beats[beat_idx] : '0;
  assign m_axis_tkeep = '1;

  // Beat sequencer: starts the cycle after a frame lands, and chains straight into the next frame after tlast.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      beat_idx      <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (push || !fifo_empty) begin
            state         <= SEND;
            beat_idx      <= '0;
            m_axis_tvalid <= 1'b1;
            m_axis_tlast  <= 1'b0;
          end
        end
        SEND: begin
          if (handshake) begin
            if (m_axis_tlast) begin
              beat_idx     <= '0;
              m_axis_tlast <= 1'b0;
              if (!(fifo_count > CNT_W'(1) || push)) begin
                state         <= IDLE;
                m_axis_tvalid <= 1'b0;
              end
            end else begin
              beat_idx     <= beat_idx + 1'b1;
              m_axis_tlast <= (beat_idx == LAST_BEAT - 1'b1);
            end
          end
        end
        default: begin
          state         <= IDLE;
          m_axis_tvalid <= 1'b0;
          m_axis_tlast  <= 1'b0;
        end
      endcase
    end
  end

  // Sequence number counts every offered frame, kept or not, so the host can spot gaps; overflow is sticky.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      seq      <= '0;
      overflow <= 1'b0;
    end else begin
      if (in_enable) seq      <= seq + 1'b1;
      if (drop)      overflow <= 1'b1;
    end
  end

`ifdef DIFFTEST_DMA_STATS_EN
  // Saturating counters of completed and dropped frames.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      frame_cnt <= '0;
      drop_cnt  <= '0;
    end else begin
      if (pop && (frame_cnt != '1)) frame_cnt <= frame_cnt + 1'b1;
      if (drop && (drop_cnt != '1)) drop_cnt  <= drop_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_difftest_dma_packer.sv
// tb/tb_difftest_dma_packer.sv - directed table-driven bench for difftest_dma_packer
module tb_difftest_dma_packer;

  localparam int DATA_W  = 512;
  localparam int N       = 8;
  localparam int PKT_W   = 4096;
  localparam int FRAME_W = 4064;

  logic                clock = 1'b0;
  logic                reset_n = 1'b0;
  logic [FRAME_W-1:0]  in_data = '0;
  logic                in_enable = 1'b0;
  logic                in_step = 1'b0;
  logic                in_zeon = 1'b0;
  logic [DATA_W-1:0]   m_axis_tdata;
  logic [DATA_W/8-1:0] m_axis_tkeep;
  logic                m_axis_tvalid;
  logic                m_axis_tready = 1'b0;
  logic                m_axis_tlast;
  logic                overflow;
`ifdef DIFFTEST_DMA_STATS_EN
  logic [31:0]         frame_cnt;
  logic [31:0]         drop_cnt;
`endif

  difftest_dma_packer #(.DATA_W(DATA_W), .FIFO_DEPTH(2)) dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .in_data       (in_data),
    .in_enable     (in_enable),
    .in_step       (in_step),
    .in_zeon       (in_zeon),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tkeep  (m_axis_tkeep),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tlast  (m_axis_tlast),
    .overflow      (overflow)
`ifdef DIFFTEST_DMA_STATS_EN
    ,
    .frame_cnt     (frame_cnt),
    .drop_cnt      (drop_cnt)
`endif
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [7:0] seq_model = 8'd0;

  typedef struct {
    logic [PKT_W-1:0] pkt;
    int               beats;
    int               first_cyc;
    int               last_cyc;
  } rx_t;

  rx_t              rx_q[$];
  logic [PKT_W-1:0] cur_pkt = '0;
  int               cur_beats = 0;
  int               cur_first = 0;
  logic             prev_stall = 1'b0;
  logic [DATA_W-1:0] prev_data = '0;
  logic             prev_last = 1'b0;

  always @(posedge clock) cyc <= cyc + 1;

  // Collect accepted beats into packets and check the bus holds steady while stalled.
  always @(negedge clock) begin
    if (!reset_n) begin
      cur_beats  = 0;
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        checks++;
        if (!(m_axis_tvalid === 1'b1 && m_axis_tdata === prev_data && m_axis_tlast === prev_last)) begin
          errors++;
          $display("FAIL axis_stable: cycle %0d valid=%b last=%b (held last=%b) data changed=%b", cyc,
                   m_axis_tvalid, m_axis_tlast, prev_last, m_axis_tdata !== prev_data);
        end
      end
      prev_stall = m_axis_tvalid && !m_axis_tready;
      prev_data  = m_axis_tdata;
      prev_last  = m_axis_tlast;
      if (m_axis_tvalid && m_axis_tready) begin
        if (cur_beats == 0) cur_first = cyc;
        if (cur_beats < N) cur_pkt[cur_beats*DATA_W +: DATA_W] = m_axis_tdata;
        cur_beats++;
        if (m_axis_tlast) begin
          rx_q.push_back('{cur_pkt, cur_beats, cur_first, cyc});
          cur_beats = 0;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [FRAME_W-1:0] make_data(input int kind);
    logic [FRAME_W-1:0] d;
    d = '0;
    for (int i = 0; i < FRAME_W/8; i++) begin
      case (kind)
        0:       d[i*8 +: 8] = 8'(i);
        1:       d[i*8 +: 8] = 8'hFF;
        2:       d[i*8 +: 8] = ~8'(i);
        default: d[i*8 +: 8] = (i % 2 == 1) ? 8'h5A : 8'hA5;
      endcase
    end
    return d;
  endfunction

  task automatic do_reset();
    reset_n       = 1'b0;
    in_enable     = 1'b0;
    m_axis_tready = 1'b0;
    tick();
    tick();
    reset_n   = 1'b1;
    seq_model = 8'd0;
    rx_q.delete();
    tick();
  endtask

  // Offer one frame for a single cycle; the expected packet is assembled here from the raw fields.
  task automatic send_frame(input int kind, input logic step, input logic zeon,
                            output logic [PKT_W-1:0] exp, output int scyc);
    in_data   = make_data(kind);
    in_step   = step;
    in_zeon   = zeon;
    in_enable = 1'b1;
    exp       = {22'b0, zeon, step, seq_model, in_data};
    scyc      = cyc;
    seq_model = seq_model + 8'd1;
    tick();
    in_enable = 1'b0;
  endtask

  task automatic get_pkt(input string name, input logic [PKT_W-1:0] exp, input bit rnd, output rx_t r);
    bit found;
    for (int i = 0; i < 300 && rx_q.size() == 0; i++) begin
      if (rnd) m_axis_tready = 1'($urandom % 2);
      tick();
    end
    checks++;
    if (rx_q.size() == 0) begin
      errors++;
      $display("FAIL %s: no packet received within budget", name);
      r = '{'0, 0, 0, 0};
    end else begin
      r = rx_q.pop_front();
      if (r.pkt !== exp) begin
        errors++;
        found = 1'b0;
        for (int k = 0; k < N; k++) begin
          if (!found && r.pkt[k*DATA_W +: DATA_W] !== exp[k*DATA_W +: DATA_W]) begin
            found = 1'b1;
            $display("FAIL %s beat %0d: got %h expected %h", name, k,
                     r.pkt[k*DATA_W +: DATA_W], exp[k*DATA_W +: DATA_W]);
          end
        end
      end
      chk({name, "_beats"}, 64'(r.beats), 64'(N));
    end
  endtask

  typedef struct {
    int         kind;
    logic       step;
    logic       zeon;
    logic [7:0] seq;
  } vec_t;

  vec_t vecs[4];

  initial begin
    logic [PKT_W-1:0] e0, e1, e2, e3;
    int s0, s1, s2, s3;
    rx_t r0, r1, r2;

    vecs[0] = '{0, 1'b1, 1'b0, 8'h00};
    vecs[1] = '{1, 1'b0, 1'b1, 8'h01};
    vecs[2] = '{2, 1'b1, 1'b1, 8'h02};
    vecs[3] = '{3, 1'b0, 1'b0, 8'h03};

    // reset state
    tick();
    chk("rst_tvalid", 64'(m_axis_tvalid), 0);
    chk("rst_tlast", 64'(m_axis_tlast), 0);
    chk("rst_tdata_zero", 64'(|m_axis_tdata), 0);
    chk("rst_overflow", 64'(overflow), 0);
    do_reset();
    chk("tkeep_ones", 64'(&m_axis_tkeep), 1);
    chk("idle_no_tvalid", 64'(m_axis_tvalid), 0);

    // single frames with tready held high: latency, layout, tlast position
    m_axis_tready = 1'b1;
    for (int v = 0; v < 4; v++) begin
      send_frame(vecs[v].kind, vecs[v].step, vecs[v].zeon, e0, s0);
      chk("t1_tvalid_next_cycle", 64'(m_axis_tvalid), 1);
      get_pkt("t1_pkt", e0, 1'b0, r0);
      chk("t1_first_beat_cycle", 64'(r0.first_cyc), 64'(s0 + 1));
      chk("t1_last_beat_cycle", 64'(r0.last_cyc), 64'(s0 + N));
      chk("t1_seq", 64'(r0.pkt[7*DATA_W + 480 +: 8]), 64'(vecs[v].seq));
      chk("t1_step", 64'(r0.pkt[7*DATA_W + 488]), 64'(vecs[v].step));
      chk("t1_zeon", 64'(r0.pkt[7*DATA_W + 489]), 64'(vecs[v].zeon));
      chk("t1_pad_zero", 64'(|r0.pkt[4095:4074]), 0);
    end
    chk("t1_byte5", 64'(e0[47:40]), 64'(8'h5A));

    // random backpressure over three frames
    do_reset();
    m_axis_tready = 1'b1;
    send_frame(1, 1'b0, 1'b0, e0, s0);
    send_frame(2, 1'b1, 1'b0, e1, s1);
    get_pkt("t2_pkt0", e0, 1'b1, r0);
    send_frame(0, 1'b0, 1'b1, e2, s2);
    get_pkt("t2_pkt1", e1, 1'b1, r1);
    get_pkt("t2_pkt2", e2, 1'b1, r2);
    chk("t2_seq0", 64'(r0.pkt[4071:4064]), 0);
    chk("t2_seq1", 64'(r1.pkt[4071:4064]), 1);
    chk("t2_seq2", 64'(r2.pkt[4071:4064]), 2);
    chk("t2_no_overflow", 64'(overflow), 0);
    m_axis_tready = 1'b1;

    // stalled sink, four enables: two held, two dropped
    do_reset();
    m_axis_tready = 1'b0;
    send_frame(0, 1'b0, 1'b0, e0, s0);
    send_frame(1, 1'b1, 1'b0, e1, s1);
    send_frame(2, 1'b0, 1'b1, e2, s2);
    send_frame(3, 1'b1, 1'b1, e3, s3);
    tick();
    tick();
    chk("t3_overflow", 64'(overflow), 1);
    chk("t3_held_tvalid", 64'(m_axis_tvalid), 1);
    chk("t3_nothing_out", 64'(rx_q.size()), 0);
`ifdef DIFFTEST_DMA_STATS_EN
    chk("t3_drop_cnt", 64'(drop_cnt), 2);
`endif
    m_axis_tready = 1'b1;
    get_pkt("t3_pkt0", e0, 1'b0, r0);
    get_pkt("t3_pkt1", e1, 1'b0, r1);
    chk("t3_seq0", 64'(r0.pkt[4071:4064]), 0);
    chk("t3_seq1", 64'(r1.pkt[4071:4064]), 1);
    send_frame(3, 1'b0, 1'b0, e2, s2);
    get_pkt("t3_pkt_next", e2, 1'b0, r2);
    chk("t3_seq_next", 64'(r2.pkt[4071:4064]), 4);
    chk("t3_overflow_sticky", 64'(overflow), 1);
`ifdef DIFFTEST_DMA_STATS_EN
    chk("t3_frame_cnt", 64'(frame_cnt), 3);
`endif

    // sequence number wraps silently across 258 enables
    do_reset();
    m_axis_tready = 1'b1;
    in_data   = make_data(0);
    in_enable = 1'b1;
    for (int i = 0; i < 258; i++) tick();
    in_enable = 1'b0;
    seq_model = 8'(258);
    for (int i = 0; i < 40; i++) tick();
    chk("wrap_drained", 64'(m_axis_tvalid), 0);
    rx_q.delete();
    send_frame(1, 1'b0, 1'b0, e0, s0);
    get_pkt("wrap_pkt", e0, 1'b0, r0);
    chk("wrap_seq", 64'(r0.pkt[4071:4064]), 2);

    // back-to-back frames stream without a bubble
    do_reset();
    m_axis_tready = 1'b1;
    send_frame(2, 1'b1, 1'b0, e0, s0);
    send_frame(3, 1'b0, 1'b1, e1, s1);
    get_pkt("t4_pkt0", e0, 1'b0, r0);
    get_pkt("t4_pkt1", e1, 1'b0, r1);
    chk("t4_start", 64'(r0.first_cyc), 64'(s0 + 1));
    chk("t4_no_bubble", 64'(r1.first_cyc), 64'(r0.last_cyc + 1));
    chk("t4_16_cycles", 64'(r1.last_cyc), 64'(r0.first_cyc + 2*N - 1));
`ifdef DIFFTEST_DMA_STATS_EN
    chk("t4_frame_cnt", 64'(frame_cnt), 2);
`endif

    // asynchronous reset in the middle of beat 3
    do_reset();
    m_axis_tready = 1'b1;
    send_frame(0, 1'b0, 1'b0, e0, s0);
    send_frame(1, 1'b0, 1'b0, e1, s1);
    send_frame(2, 1'b0, 1'b0, e2, s2);
    tick();
    chk("t5_overflow_before", 64'(overflow), 1);
    chk("t5_tvalid_before", 64'(m_axis_tvalid), 1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("t5_async_tvalid", 64'(m_axis_tvalid), 0);
    chk("t5_async_tlast", 64'(m_axis_tlast), 0);
    chk("t5_async_tdata", 64'(|m_axis_tdata), 0);
    chk("t5_async_overflow", 64'(overflow), 0);
    tick();
    reset_n   = 1'b1;
    seq_model = 8'd0;
    chk("t5_no_partial_pkt", 64'(rx_q.size()), 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t5_empty_no_tvalid", 64'(m_axis_tvalid), 0);
    end
    send_frame(3, 1'b1, 1'b0, e0, s0);
    get_pkt("t5_pkt", e0, 1'b0, r0);
    chk("t5_seq", 64'(r0.pkt[4071:4064]), 0);
    chk("t5_start", 64'(r0.first_cyc), 64'(s0 + 1));

    // full FIFO, new frame coincides with the tlast handshake
    do_reset();
    m_axis_tready = 1'b1;
    send_frame(0, 1'b1, 1'b1, e0, s0);
    send_frame(1, 1'b0, 1'b0, e1, s1);
    for (int i = 0; i < 30 && !(m_axis_tvalid && m_axis_tlast); i++) tick();
    chk("t6_at_tlast", 64'(m_axis_tvalid && m_axis_tlast), 1);
    send_frame(2, 1'b1, 1'b0, e2, s2);
    chk("t6_no_overflow", 64'(overflow), 0);
    get_pkt("t6_pkt0", e0, 1'b0, r0);
    get_pkt("t6_pkt1", e1, 1'b0, r1);
    get_pkt("t6_pkt2", e2, 1'b0, r2);
    chk("t6_seq2", 64'(r2.pkt[4071:4064]), 2);
    chk("t6_order", 64'(r2.first_cyc), 64'(r1.last_cyc + 1));
`ifdef DIFFTEST_DMA_STATS_EN
    chk("t6_drop_cnt", 64'(drop_cnt), 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
